// File: rtl/alu_ctrl_pkg.sv
// Shared key codes, state encodings and op limit
// for the calculator entry controller.
package alu_ctrl_pkg;

  localparam logic [3:0] KEY_0     = 4'h0;
  localparam logic [3:0] KEY_9     = 4'h9;
  localparam logic [3:0] KEY_SEL_A = 4'hA;
  localparam logic [3:0] KEY_SEL_B = 4'hB;
  localparam logic [3:0] KEY_OP    = 4'hC;
  localparam logic [3:0] KEY_BS    = 4'hD;
  localparam logic [3:0] KEY_ENT   = 4'hE;

  localparam logic [3:0] OP_MAX = 4'd7;

  typedef enum logic [2:0] {
    ST_ENTRY_A  = 3'd0,
    ST_ENTRY_B  = 3'd1,
    ST_ENTRY_OP = 3'd2,
    ST_CONVERT  = 3'd3,
    ST_RUN      = 3'd4,
    ST_RESULT   = 3'd5
  } state_t;

  function automatic logic is_nav(
    input logic [3:0] k
  );
    return (k == KEY_SEL_A) ||
           (k == KEY_SEL_B) ||
           (k == KEY_OP);
  endfunction

endpackage

// File: rtl/bcd_to_bin.sv
// Sequential BCD to binary converter, one digit
// per cycle, most significant digit first.
module bcd_to_bin #(
  parameter int DIGITS = 3,
  parameter int W      = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  input  logic [4*DIGITS-1:0] i_bcd,
  output logic                o_done,
  output logic [W-1:0]        o_value
);

  localparam int CW = $clog2(DIGITS + 1);

  logic [4*DIGITS-1:0] r_sr;
  logic [W-1:0]        r_acc;
  logic [CW-1:0]       r_cnt;
  logic                r_busy;

  logic [3:0]   w_msd;
  logic [W-1:0] w_next;
  logic         w_last;

  assign w_msd  = r_sr[4*DIGITS-1 -: 4];
  assign w_next = W'(r_acc * W'(10)) + W'(w_msd);
  assign w_last = r_busy &&
                  (r_cnt == CW'(DIGITS - 1));

  // done is flagged in the last step so the
  // caller can commit the value on that edge
  assign o_done  = w_last;
  assign o_value = w_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sr   <= '0;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_sr   <= i_bcd;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_acc <= w_next;
      r_sr  <= r_sr << 4;
      r_cnt <= r_cnt + 1'b1;
      if (w_last)
        r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_entry_ctrl.sv
// Keypad entry controller: edits decimal operands,
// converts them to binary and launches the ALU.
module alu_entry_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter int W      = 10
) (
  input  logic                CLK100MHZ,
  input  logic                RST,
  input  logic [3:0]          KEY_CODE,
  input  logic                KEY_STB,
  output logic [W-1:0]        ALU_A,
  output logic [W-1:0]        ALU_B,
  output logic [2:0]          ALU_OP,
  output logic                ALU_START,
  input  logic                ALU_DONE,
  output logic [4*DIGITS-1:0] DISP_BCD,
  output logic [2:0]          STATE,
  output logic                ERR
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);

  state_t        r_state, w_state_nx;
  logic [BW-1:0] r_buf, w_buf_nx;
  logic [BW-1:0] r_disp, w_disp_nx;
  logic [CW-1:0] r_cnt, w_cnt_nx;
  logic [2:0]    r_pend, w_pend_nx;
  logic          r_pend_vld, w_pend_vld_nx;
  logic          r_sel_b, w_sel_b_nx;
  logic [W-1:0]  r_a, r_b;
  logic [2:0]    r_op;
  logic          r_start, r_err;

  logic         w_start, w_err;
  logic         w_conv_go, w_op_ld;
  logic         w_commit_a, w_commit_b;
  logic         w_conv_done;
  logic [W-1:0] w_conv_val;
  logic         w_dig, w_full, w_empty;

  assign w_dig   = KEY_CODE <= KEY_9;
  assign w_full  = r_cnt == CW'(DIGITS);
  assign w_empty = r_cnt == '0;

  bcd_to_bin #(
    .DIGITS (DIGITS),
    .W      (W)
  ) u_conv (
    .clk     (CLK100MHZ),
    .rst     (RST),
    .i_start (w_conv_go),
    .i_bcd   (r_buf),
    .o_done  (w_conv_done),
    .o_value (w_conv_val)
  );

  always_ff @(posedge CLK100MHZ or posedge RST) begin
    if (RST)
      r_state <= ST_ENTRY_A;
    else
      r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx    = r_state;
    w_buf_nx      = r_buf;
    w_cnt_nx      = r_cnt;
    w_pend_nx     = r_pend;
    w_pend_vld_nx = r_pend_vld;
    w_sel_b_nx    = r_sel_b;
    w_start       = 1'b0;
    w_err         = 1'b0;
    w_conv_go     = 1'b0;
    w_op_ld       = 1'b0;
    w_commit_a    = 1'b0;
    w_commit_b    = 1'b0;

    if (r_state == ST_RUN && ALU_DONE)
      w_state_nx = ST_RESULT;

    if (r_state == ST_CONVERT && w_conv_done) begin
      w_commit_a = !r_sel_b;
      w_commit_b = r_sel_b;
      w_state_nx = r_sel_b ? ST_ENTRY_OP
                           : ST_ENTRY_B;
      w_pend_nx     = 3'd0;
      w_pend_vld_nx = 1'b0;
    end

    if (KEY_STB) begin
      if (r_state == ST_CONVERT ||
          r_state == ST_RUN) begin
        w_err = 1'b1;
      end else if (is_nav(KEY_CODE)) begin
        w_buf_nx      = '0;
        w_cnt_nx      = '0;
        w_pend_nx     = 3'd0;
        w_pend_vld_nx = 1'b0;
        unique case (1'b1)
          KEY_CODE == KEY_SEL_A:
            w_state_nx = ST_ENTRY_A;
          KEY_CODE == KEY_SEL_B:
            w_state_nx = ST_ENTRY_B;
          default:
            w_state_nx = ST_ENTRY_OP;
        endcase
      end else begin
        unique case (r_state)
          ST_ENTRY_OP: begin
            unique case (1'b1)
              w_dig: begin
                if (KEY_CODE > OP_MAX) begin
                  w_err = 1'b1;
                end else begin
                  w_pend_nx     = KEY_CODE[2:0];
                  w_pend_vld_nx = 1'b1;
                end
              end
              KEY_CODE == KEY_BS: begin
                w_pend_nx     = 3'd0;
                w_pend_vld_nx = 1'b0;
              end
              KEY_CODE == KEY_ENT: begin
                if (r_pend_vld) begin
                  w_op_ld    = 1'b1;
                  w_start    = 1'b1;
                  w_state_nx = ST_RUN;
                end else begin
                  w_err = 1'b1;
                end
              end
              default: w_err = 1'b1;
            endcase
          end
          ST_RESULT: begin
            unique case (1'b1)
              w_dig: begin
                w_state_nx = ST_ENTRY_A;
                w_buf_nx   = BW'(KEY_CODE);
                w_cnt_nx   = CW'(1);
              end
              KEY_CODE == KEY_ENT: begin
                w_start    = 1'b1;
                w_state_nx = ST_RUN;
              end
              KEY_CODE == KEY_BS: ;
              default: w_err = 1'b1;
            endcase
          end
          default: begin
            unique case (1'b1)
              w_dig: begin
                if (w_full) begin
                  w_err = 1'b1;
                end else begin
                  w_buf_nx = (r_buf << 4) |
                             BW'(KEY_CODE);
                  w_cnt_nx = r_cnt + 1'b1;
                end
              end
              KEY_CODE == KEY_BS: begin
                if (!w_empty) begin
                  w_buf_nx = r_buf >> 4;
                  w_cnt_nx = r_cnt - 1'b1;
                end
              end
              KEY_CODE == KEY_ENT: begin
                w_conv_go  = 1'b1;
                w_sel_b_nx = r_state == ST_ENTRY_B;
                w_state_nx = ST_CONVERT;
                w_buf_nx   = '0;
                w_cnt_nx   = '0;
              end
              default: w_err = 1'b1;
            endcase
          end
        endcase
      end
    end
  end

  // display tracks the next edit view, else holds
  always_comb begin
    w_disp_nx = r_disp;
    unique case (w_state_nx)
      ST_ENTRY_A, ST_ENTRY_B:
        w_disp_nx = w_buf_nx;
      ST_ENTRY_OP:
        w_disp_nx = BW'(w_pend_nx);
      default:
        w_disp_nx = r_disp;
    endcase
  end

  always_ff @(posedge CLK100MHZ or posedge RST) begin
    if (RST) begin
      r_buf      <= '0;
      r_cnt      <= '0;
      r_pend     <= 3'd0;
      r_pend_vld <= 1'b0;
      r_sel_b    <= 1'b0;
      r_disp     <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_op       <= 3'd0;
      r_start    <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_buf      <= w_buf_nx;
      r_cnt      <= w_cnt_nx;
      r_pend     <= w_pend_nx;
      r_pend_vld <= w_pend_vld_nx;
      r_sel_b    <= w_sel_b_nx;
      r_disp     <= w_disp_nx;
      r_start    <= w_start;
      r_err      <= w_err;
      if (w_op_ld)
        r_op <= r_pend;
      if (w_commit_a)
        r_a <= w_conv_val;
      if (w_commit_b)
        r_b <= w_conv_val;
    end
  end

  assign ALU_A     = r_a;
  assign ALU_B     = r_b;
  assign ALU_OP    = r_op;
  assign ALU_START = r_start;
  assign DISP_BCD  = r_disp;
  assign STATE     = r_state;
  assign ERR       = r_err;

endmodule

// File: tb/tb_alu_entry_ctrl.sv
// Bench for alu_entry_ctrl: vector table, directed
// sequences and random keys against a keypad model.
module tb_alu_entry_ctrl;
  import alu_ctrl_pkg::*;

  localparam int DIGITS = 3;
  localparam int W      = 10;
  localparam int BW     = 4 * DIGITS;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    key;
  logic          stb;
  logic          done;
  logic [W-1:0]  alu_a, alu_b;
  logic [2:0]    alu_op;
  logic          alu_start;
  logic [BW-1:0] disp;
  logic [2:0]    st;
  logic          err;

  always #5 clk = ~clk;

  alu_entry_ctrl #(
    .DIGITS (DIGITS),
    .W      (W)
  ) dut (
    .CLK100MHZ (clk),
    .RST       (rst),
    .KEY_CODE  (key),
    .KEY_STB   (stb),
    .ALU_A     (alu_a),
    .ALU_B     (alu_b),
    .ALU_OP    (alu_op),
    .ALU_START (alu_start),
    .ALU_DONE  (done),
    .DISP_BCD  (disp),
    .STATE     (st),
    .ERR       (err)
  );

  int n_run  = 0;
  int n_fail = 0;
  int n_start = 0;

  always @(posedge clk)
    if (alu_start === 1'b1) n_start++;

  // keypad model: digits held as a list of ints
  state_t        m_state;
  int            m_q[$];
  int            m_a, m_b, m_op, m_pend;
  bit            m_tgt_b;
  int            m_val;
  logic [BW-1:0] m_disp;

  function automatic logic [BW-1:0] pack_q();
    logic [BW-1:0] v;
    int n;
    v = '0;
    n = m_q.size();
    for (int i = 0; i < n; i++)
      v[4*(n-1-i) +: 4] = 4'(m_q[i]);
    return v;
  endfunction

  task automatic model_reset();
    m_state = ST_ENTRY_A;
    m_q.delete();
    m_a = 0; m_b = 0; m_op = 0;
    m_pend = -1;
    m_disp = '0;
  endtask

  task automatic model_key(
    input  int k,
    output bit e,
    output bit s,
    output bit conv
  );
    e = 0; s = 0; conv = 0;
    if (m_state == ST_RUN) begin
      e = 1;
    end else if (k == 'hA || k == 'hB || k == 'hC) begin
      m_q.delete();
      m_pend = -1;
      m_state = (k == 'hA) ? ST_ENTRY_A :
                (k == 'hB) ? ST_ENTRY_B : ST_ENTRY_OP;
    end else begin
      case (m_state)
        ST_ENTRY_A, ST_ENTRY_B: begin
          if (k <= 9) begin
            if (m_q.size() < DIGITS) m_q.push_back(k);
            else e = 1;
          end else if (k == 'hD) begin
            if (m_q.size() > 0) void'(m_q.pop_back());
          end else if (k == 'hE) begin
            conv = 1;
            m_val = 0;
            foreach (m_q[i]) m_val = m_val * 10 + m_q[i];
            m_tgt_b = (m_state == ST_ENTRY_B);
            m_q.delete();
            m_state = ST_CONVERT;
          end else e = 1;
        end
        ST_ENTRY_OP: begin
          if (k <= 7) m_pend = k;
          else if (k <= 9) e = 1;
          else if (k == 'hD) m_pend = -1;
          else if (k == 'hE) begin
            if (m_pend >= 0) begin
              m_op = m_pend; s = 1; m_state = ST_RUN;
            end else e = 1;
          end else e = 1;
        end
        ST_RESULT: begin
          if (k <= 9) begin
            m_state = ST_ENTRY_A;
            m_q.delete();
            m_q.push_back(k);
          end else if (k == 'hE) begin
            s = 1; m_state = ST_RUN;
          end else if (k != 'hD) e = 1;
        end
        default: e = 1;
      endcase
    end
    if (m_state == ST_ENTRY_A || m_state == ST_ENTRY_B)
      m_disp = pack_q();
    else if (m_state == ST_ENTRY_OP)
      m_disp = (m_pend < 0) ? '0 : BW'(m_pend);
  endtask

  task automatic check(
    input string nm,
    input bit    e,
    input bit    s
  );
    n_run++;
    if (st !== 3'(m_state) || alu_a !== W'(m_a) ||
        alu_b !== W'(m_b) || alu_op !== 3'(m_op) ||
        disp !== m_disp || err !== e ||
        alu_start !== s) begin
      n_fail++;
      $display("FAIL %s: got st=%0d a=%0d b=%0d op=%0d disp=%h err=%b start=%b want st=%0d a=%0d b=%0d op=%0d disp=%h err=%b start=%b",
        nm, st, alu_a, alu_b, alu_op, disp, err,
        alu_start, m_state, m_a, m_b, m_op, m_disp,
        e, s);
    end
  endtask

  task automatic expect_eq(
    input string nm,
    input int    got,
    input int    want
  );
    n_run++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d",
               nm, got, want);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    check("reset", 0, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic press(input logic [3:0] k);
    bit e, s, conv;
    @(negedge clk);
    key = k;
    stb = 1'b1;
    @(negedge clk);
    stb = 1'b0;
    key = 4'h0;
    model_key(int'(k), e, s, conv);
    check($sformatf("key_%h", k), e, s);
    if (conv) begin
      for (int i = 1; i < DIGITS; i++) begin
        @(negedge clk);
        check("convert", 0, 0);
      end
      @(negedge clk);
      if (m_tgt_b) begin
        m_b = m_val;
        m_state = ST_ENTRY_OP;
        m_pend = -1;
      end else begin
        m_a = m_val;
        m_state = ST_ENTRY_B;
      end
      m_disp = '0;
      check("commit", 0, 0);
    end
  endtask

  task automatic pulse_done();
    @(negedge clk);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    if (m_state == ST_RUN) m_state = ST_RESULT;
    check("alu_done", 0, 0);
  endtask

  typedef struct {
    logic [3:0]    k;
    logic          e;
    state_t        s;
    logic [BW-1:0] d;
  } tv_t;

  tv_t tv[17];
  int  n0;

  initial begin
    rst  = 1'b1;
    stb  = 1'b0;
    key  = 4'h0;
    done = 1'b0;
    model_reset();
    tv[0]  = '{4'h4, 1'b0, ST_ENTRY_A,  12'h004};
    tv[1]  = '{4'h5, 1'b0, ST_ENTRY_A,  12'h045};
    tv[2]  = '{4'h6, 1'b0, ST_ENTRY_A,  12'h456};
    tv[3]  = '{4'h7, 1'b1, ST_ENTRY_A,  12'h456};
    tv[4]  = '{4'hD, 1'b0, ST_ENTRY_A,  12'h045};
    tv[5]  = '{4'hD, 1'b0, ST_ENTRY_A,  12'h004};
    tv[6]  = '{4'hD, 1'b0, ST_ENTRY_A,  12'h000};
    tv[7]  = '{4'hD, 1'b0, ST_ENTRY_A,  12'h000};
    tv[8]  = '{4'h9, 1'b0, ST_ENTRY_A,  12'h009};
    tv[9]  = '{4'hD, 1'b0, ST_ENTRY_A,  12'h000};
    tv[10] = '{4'hC, 1'b0, ST_ENTRY_OP, 12'h000};
    tv[11] = '{4'h9, 1'b1, ST_ENTRY_OP, 12'h000};
    tv[12] = '{4'hE, 1'b1, ST_ENTRY_OP, 12'h000};
    tv[13] = '{4'h3, 1'b0, ST_ENTRY_OP, 12'h003};
    tv[14] = '{4'h8, 1'b1, ST_ENTRY_OP, 12'h003};
    tv[15] = '{4'hD, 1'b0, ST_ENTRY_OP, 12'h000};
    tv[16] = '{4'hA, 1'b0, ST_ENTRY_A,  12'h000};

    repeat (2) @(negedge clk);
    do_reset();

    foreach (tv[i]) begin
      press(tv[i].k);
      n_run++;
      if (err !== tv[i].e || st !== 3'(tv[i].s) ||
          disp !== tv[i].d) begin
        n_fail++;
        $display("FAIL vec%0d: got err=%b st=%0d disp=%h want err=%b st=%0d disp=%h",
          i, err, st, disp, tv[i].e, tv[i].s,
          tv[i].d);
      end
    end

    do_reset();
    press(4'h1); press(4'h2); press(4'h3);
    press(4'hE);
    expect_eq("a_123", int'(alu_a), 123);
    expect_eq("st_b", int'(st), int'(ST_ENTRY_B));
    press(4'hA);
    press(4'h9); press(4'hD); press(4'hE);
    expect_eq("a_zero", int'(alu_a), 0);
    do_reset();
    press(4'hD);
    expect_eq("bs_empty1", int'(err), 0);
    press(4'hD);
    expect_eq("bs_empty2", int'(err), 0);

    do_reset();
    press(4'h1); press(4'h2); press(4'hE);
    press(4'h3); press(4'h4); press(4'hE);
    press(4'h2);
    n0 = n_start;
    press(4'hE);
    expect_eq("run_st", int'(st), int'(ST_RUN));
    press(4'h5);
    expect_eq("run_err", int'(err), 1);
    expect_eq("start_once", n_start - n0, 1);
    pulse_done();
    expect_eq("result", int'(st), int'(ST_RESULT));
    press(4'hE);
    expect_eq("rerun_a", int'(alu_a), 12);
    expect_eq("rerun_b", int'(alu_b), 34);
    expect_eq("rerun_op", int'(alu_op), 2);
    do_reset();
    expect_eq("start_twice", n_start - n0, 2);
    pulse_done();
    expect_eq("done_ignored", int'(st),
              int'(ST_ENTRY_A));

    do_reset();
    for (int it = 0; it < 600; it++) begin
      int r;
      r = $urandom_range(0, 9);
      if ((m_state == ST_RUN && r < 5) || r == 0)
        pulse_done();
      else if (r < 3)
        press(KEY_ENT);
      else
        press(4'($urandom_range(0, 15)));
    end

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_entry_ctrl.md
ALU_ENTRY_CTRL -- requirements
Module: alu_entry_ctrl

Interface
REQ-001 SHALL have parameter DIGITS, default 3, meaning maximum decimal digits per operand.
REQ-002 SHALL have parameter W, default 10, meaning binary operand width; W >= ceil(log2(10^DIGITS)).
REQ-003 SHALL have port CLK100MHZ  in  1  the single system clock; all logic on its rising edge.
REQ-004 SHALL have port RST  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port KEY_CODE  in  4  key code: 0-9 digit, A select-A, B select-B, C op-select, D backspace, E enter.
REQ-006 SHALL have port KEY_STB  in  1  one-cycle pulse; KEY_CODE is valid in that cycle.
REQ-007 SHALL have port ALU_A  out  W  committed binary operand A.
REQ-008 SHALL have port ALU_B  out  W  committed binary operand B.
REQ-009 SHALL have port ALU_OP  out  3  committed operation select.
REQ-010 SHALL have port ALU_START  out  1  one-cycle pulse requesting an ALU operation.
REQ-011 SHALL have port ALU_DONE  in  1  one-cycle pulse, ALU result ready.
REQ-012 SHALL have port DISP_BCD  out  4*DIGITS  digit buffer being edited, least significant digit in [3:0].
REQ-013 SHALL have port STATE  out  3  current state encoding, for display.
REQ-014 SHALL have port ERR  out  1  one-cycle pulse on a rejected key.

Function
REQ-015 SHALL implement states ENTRY_A, ENTRY_B, ENTRY_OP, CONVERT, RUN, RESULT.
REQ-016 SHALL act on a key only in the cycle KEY_STB=1; it SHALL take effect at the next clock edge.
REQ-017 In ENTRY_A/ENTRY_B, a digit SHALL shift into the buffer (buf <= {buf, digit}) when the count < DIGITS; otherwise it SHALL be dropped with ERR.
REQ-018 In ENTRY_A/ENTRY_B, backspace SHALL shift the buffer right by one digit and decrement the count; on an empty buffer it SHALL have no effect and no ERR.
REQ-019 Enter in ENTRY_A/ENTRY_B SHALL go to CONVERT, which takes exactly DIGITS cycles (acc <= acc*10 + digit, MSD first); the result SHALL load ALU_A or ALU_B; then ENTRY_A->ENTRY_B or ENTRY_B->ENTRY_OP, with the buffer cleared.
REQ-020 An empty buffer on enter SHALL commit value 0.
REQ-021 Key A or B SHALL jump to ENTRY_A or ENTRY_B from ENTRY_*/RESULT, clear the buffer and leave committed operands unchanged; key C SHALL jump to ENTRY_OP.
REQ-022 In ENTRY_OP, digits 0-7 SHALL load a pending op; digits 8-9 SHALL give ERR.
REQ-023 Enter in ENTRY_OP SHALL, if an op is pending, commit ALU_OP, pulse ALU_START in the cycle of entry to RUN, and go to RUN; with no op pending it SHALL give ERR and stay in ENTRY_OP.
REQ-024 RUN SHALL wait for ALU_DONE, then go to RESULT; there is no timeout.
REQ-025 In CONVERT and RUN, every KEY_STB SHALL be dropped with ERR.
REQ-026 In RESULT, a digit SHALL start a new A entry with that digit; enter SHALL re-run the same operation (ALU_START pulse, go to RUN).
REQ-027 DISP_BCD SHALL show the buffer in ENTRY_A/ENTRY_B, the op in its low digit in ENTRY_OP, and SHALL hold its value in CONVERT/RUN/RESULT.
REQ-028 ALU_A, ALU_B and ALU_OP SHALL change only at commit and SHALL be stable from ALU_START until ALU_DONE.

Reset
REQ-029 RST=1 SHALL immediately force: state ENTRY_A; ALU_A, ALU_B, ALU_OP, DISP_BCD, buffer, count, pending op = 0; ALU_START = 0; ERR = 0.
REQ-030 Reset asserted in CONVERT or RUN SHALL abort the operation; an ALU_DONE after reset SHALL be ignored (ENTRY_A state).

Structure
REQ-031 The key code constants (0x0-0xE), the state encodings and the op range limit SHALL be in shared package alu_ctrl_pkg.
REQ-032 The sequential BCD-to-binary converter SHALL be sub-module bcd_to_bin (start, buffer in, done, value out).

Verification
REQ-033 Keys 1,2,3,E -> after 3 CONVERT cycles ALU_A=123 and state ENTRY_B.
REQ-034 Keys 4,5,6,7 in ENTRY_A -> the fourth digit gives an ERR pulse and DISP_BCD=0x456.
REQ-035 Keys 9,D,E -> ALU_A=0; keys D,D on an empty buffer -> no ERR.
REQ-036 Sequence A=12, B=34, op 2, E -> one ALU_START pulse; a key during RUN gives ERR; ALU_DONE -> RESULT; E -> second ALU_START with the same operands.
REQ-037 ENTRY_OP, key 9 -> ERR; E with no op pending -> ERR, state unchanged.
REQ-038 RST pulse mid-RUN -> all outputs 0, ENTRY_A; a later ALU_DONE -> no state change.
